// File: rtl/serial_defs.sv
// Shared definitions for the serial receiver: FSM state encodings and the idle line level.
package serial_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_rx_if.sv
// Parallel output port of the serial receiver: received word, valid/ready handshake, status pulses.
interface serial_rx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_out,
    output valid,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data_out,
    input  valid,
    input  frame_err,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= {2{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/serial_rx.sv
// Start/stop framed serial receiver: synchronise, sample mid-bit, deserialise LSB first,
// check the stop bit and hand the word out on a valid/ready port.
module serial_rx
  import serial_defs::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  serial_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [BW-1:0]        bit_idx_reg, bit_idx_next;
  logic                 sample_bit;
  logic                 load_reg, load_next;
  logic                 err_reg, err_next;
  logic [DATA_BITS-1:0] bit_sel;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg, frame_err_reg, overrun_reg;

  sync_2ff #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      load_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      load_reg    <= load_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    sample_bit   = 1'b0;
    load_next    = 1'b0;
    err_next     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
        if (rx_s != LINE_IDLE) state_next = ST_START;
      end
      ST_START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = (rx_s == LINE_IDLE) ? ST_IDLE : ST_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          sample_bit = 1'b1;
          if (bit_idx_reg == LAST_IDX) state_next = ST_STOP;
          else bit_idx_next = bit_idx_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next = '0;
          if (rx_s == LINE_IDLE) begin
            load_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_BREAK: begin
        // A stuck-low line must return high before another start bit is recognised.
        cnt_next = '0;
        if (rx_s == LINE_IDLE) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_bit_sel
    assign bit_sel[gi] = sample_bit && (bit_idx_reg == BW'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= (shift_reg & ~bit_sel) | (bit_sel & {DATA_BITS{rx_s}});
    end
  end

  // The stop-bit verdict is registered once before it reaches the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= err_reg;
      overrun_reg   <= load_reg && valid_reg && !bus.ready;
      if (load_reg) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else if (valid_reg && bus.ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_reg;
  assign bus.valid     = valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: reset, framing, false start, frame error, overrun, consume-on-load.
module tb_serial_rx;

  localparam int CPB = 16;

  logic clk;
  logic rst;
  logic rx;

  serial_rx_if #(.DATA_BITS(8)) bus ();

  serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e0_cyc = 0;
  int rise_cnt, rise_cyc, valid_cycles, ferr_cnt, ferr_cyc, ovr_cnt, ovr_cyc;
  logic [7:0] rise_data;
  logic valid_q = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter and event recorder, sampled 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (bus.valid && !valid_q) begin
        rise_cnt  = rise_cnt + 1;
        rise_cyc  = cyc;
        rise_data = bus.data_out;
      end
      if (bus.valid) valid_cycles = valid_cycles + 1;
      if (bus.frame_err) begin
        ferr_cnt = ferr_cnt + 1;
        ferr_cyc = cyc;
      end
      if (bus.overrun) begin
        ovr_cnt = ovr_cnt + 1;
        ovr_cyc = cyc;
      end
      valid_q = bus.valid;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rise_cnt     = 0;
    rise_cyc     = 0;
    valid_cycles = 0;
    ferr_cnt     = 0;
    ferr_cyc     = 0;
    ovr_cnt      = 0;
    ovr_cyc      = 0;
    rise_data    = 8'h00;
  endtask

  // Called at a falling edge; the next rising edge is E0. Optionally pulses ready
  // for exactly the edge E0+155 (the load edge of this frame).
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit pulse_ready);
    logic [9:0] bits;
    bits   = {stop, d, 1'b0};
    e0_cyc = cyc + 1;
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      for (int k = 0; k < CPB; k++) begin
        if (pulse_ready) bus.ready = ((cyc + 1 - e0_cyc) == 155);
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clear_mon();
    rst       = 1'b0;
    rx        = 1'b1;
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid",     32'(bus.valid),     32'd0);
    check("reset_data",      32'(bus.data_out),  32'h00);
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
    check("reset_overrun",   32'(bus.overrun),   32'd0);
    rst = 1'b1;
    idle(10);

    // Reset in the middle of a frame: start bit plus three data bits, then a 10 ns reset.
    bus.ready = 1'b1;
    rx = 1'b0; repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (CPB) @(negedge clk);
    rx = 1'b0; repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (CPB) @(negedge clk);
    rst = 1'b0;
    #3;
    check("midrst_valid", 32'(bus.valid),    32'd0);
    check("midrst_data",  32'(bus.data_out), 32'h00);
    #7;
    rst = 1'b1;
    rx  = 1'b1;
    idle(20);
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    check("midrst_next_cnt",  32'(rise_cnt),  32'd1);
    check("midrst_next_data", 32'(rise_data), 32'h3C);

    // Single frame with ready held high.
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("single_latency",   32'(rise_cyc - e0_cyc), 32'd155);
    check("single_data",      32'(rise_data),         32'hA5);
    check("single_valid_len", 32'(valid_cycles),      32'd1);
    check("single_frame_err", 32'(ferr_cnt),          32'd0);
    check("single_overrun",   32'(ovr_cnt),           32'd0);
    check("single_data_hold", 32'(bus.data_out),      32'hA5);

    // Five-cycle low glitch is rejected, then a real frame is still accepted.
    clear_mon();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    check("glitch_no_valid", 32'(rise_cnt), 32'd0);
    check("glitch_no_ferr",  32'(ferr_cnt), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    check("glitch_next_data", 32'(rise_data), 32'h5A);
    check("glitch_next_cnt",  32'(rise_cnt),  32'd1);

    // Stop bit forced low, line held low another 40 cycles, then released.
    clear_mon();
    send_frame(8'h81, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(200);
    check("ferr_pulses",    32'(ferr_cnt),          32'd1);
    check("ferr_latency",   32'(ferr_cyc - e0_cyc), 32'd155);
    check("ferr_no_valid",  32'(rise_cnt),          32'd0);
    check("ferr_data_keep", 32'(bus.data_out),      32'h5A);

    // Overrun: two back-to-back frames with ready low.
    clear_mon();
    bus.ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(5);
    check("ovr_pulses",  32'(ovr_cnt),          32'd1);
    check("ovr_latency", 32'(ovr_cyc - e0_cyc), 32'd155);
    check("ovr_valid",   32'(bus.valid),        32'd1);
    check("ovr_data",    32'(bus.data_out),     32'h22);
    check("ovr_rises",   32'(rise_cnt),         32'd1);
    bus.ready = 1'b1;
    @(negedge clk);
    check("ovr_consume", 32'(bus.valid), 32'd0);
    bus.ready = 1'b0;
    idle(10);

    // Consume of the old word on the same edge the new word loads.
    clear_mon();
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b1);
    idle(5);
    check("simul_overrun", 32'(ovr_cnt),      32'd0);
    check("simul_valid",   32'(bus.valid),    32'd1);
    check("simul_data",    32'(bus.data_out), 32'h44);
    check("simul_rises",   32'(rise_cnt),     32'd1);
    bus.ready = 1'b1;
    @(negedge clk);
    check("simul_consume", 32'(bus.valid), 32'd0);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
# serial_rx

Single-line serial receiver that recovers start/stop-framed data words from an asynchronous bit stream and presents them on a valid/ready parallel port. It is the receiving end of the team's serial test-stimulus path: a bench or upstream transmitter toggles one data line, and this block synchronises, samples, deserialises and checks each frame. It sits between an external `rx` pin and any parallel consumer.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame, LSB first, range 5–9.

- `clk` input 1: sole clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset (`rst == 0` resets the block).
- `rx` input 1: serial line. Idle level is 1. Asynchronous to `clk`.
- `data_out` output DATA_BITS: most recently received word.
- `valid` output 1: `data_out` holds an unconsumed word.
- `ready` input 1: consumer accepts the word when `valid && ready` at a clock edge.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0.
- `overrun` output 1: one-cycle pulse when a new word overwrites an unconsumed word.

## Operation
- **Input synchroniser.** `rx` passes through two flops. Both reset to 1. The synchronised signal is `rx_s`.
- **State machine.**
  - IDLE: `cnt` = 0. `rx_s == 0` → START.
  - START: count to CLKS_PER_BIT/2 − 1, then resample `rx_s`.
    - `rx_s == 1` is a glitch or false start → IDLE. No output activity.
    - `rx_s == 0` → DATA, with `cnt` = 0 and `bit_idx` = 0.
  - DATA: each time `cnt` reaches CLKS_PER_BIT − 1, sample `rx_s` into shift register bit `bit_idx` (LSB first) and clear `cnt`.
    - When `bit_idx` = DATA_BITS − 1 has been sampled → STOP.
  - STOP: when `cnt` reaches CLKS_PER_BIT − 1, sample `rx_s`.
    - 1 → load `data_out`, set `valid`, go to IDLE.
    - 0 → pulse `frame_err`, leave `data_out` and `valid` unchanged, go to BREAK.
  - BREAK: wait for `rx_s == 1`, then → IDLE. A line held low never produces repeated frames.
- **Counter width.** `cnt` is $clog2(CLKS_PER_BIT) bits and `bit_idx` is $clog2(DATA_BITS) bits. Neither wraps except through the explicit clears above.
- **Output handshake.**
  - `valid` clears on an edge with `valid && ready` and no simultaneous load.
  - `data_out` is stable while `valid == 1`, unless overwritten by a load.
  - Load while `valid && !ready`: `data_out` takes the new word, `valid` stays 1, `overrun` pulses.
  - Load and `valid && ready` on the same edge: the old word is consumed and the new word loaded. `valid` stays 1 and there is no `overrun`.
- **Reset.**
  - Any reset, including one mid-frame, returns the FSM to IDLE and clears `cnt` and `bit_idx`.
  - Outputs reset to `data_out` = 0, `valid` = 0, `frame_err` = 0, `overrun` = 0.
  - Synchroniser flops reset to 1.
  - A partial frame is discarded.

## Timing
- Sampling points are mid-bit: CLKS_PER_BIT/2 after the detected start edge, then every CLKS_PER_BIT.
- Let E0 be the first rising edge at which `rx` is 0 at the synchroniser input.
  - `valid` rises exactly (DATA_BITS+1)·CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 edges after E0.
  - With default parameters this is 155.
- `frame_err` occurs on the same cycle a successful frame would have raised `valid`. It is high for exactly one cycle.
- After `valid`, the FSM is in IDLE. The next start bit is accepted immediately, so back-to-back frames with one stop bit are supported.
- `ready` has no combinational path to any output. All outputs are registered.

## Structure
- Shared package or header `serial_defs` holds:
  - state encodings (IDLE, START, DATA, STOP, BREAK);
  - the idle line level constant (1).
- Sub-module `sync_2ff`: a two-flop synchroniser with asynchronous active-low reset and parameterised reset value. Here it is instantiated with reset value 1.
- Everything else (FSM, counters, shift register, output register) lives in `serial_rx`.

## Test plan
- **Reset mid-frame.** Drive a start bit plus 3 data bits, then pulse `rst` low for 10 ns.
  - During reset: `valid` = 0, `data_out` = 0.
  - Next full frame 0x3C is received correctly.
- **Single frame.** Send 0xA5 (LSB first) with `ready` = 1.
  - `valid` is high for 1 cycle at edge E0+155.
  - `data_out` = 0xA5.
  - `frame_err` = `overrun` = 0.
- **False start.** Drive a 5-cycle low glitch on `rx`.
  - FSM returns to IDLE.
  - No `valid`, no `frame_err`.
- **Frame error.** Send 0x81 with the stop bit forced to 0, then hold `rx` low 40 cycles.
  - `frame_err` is a single pulse.
  - `valid` stays 0.
  - No new frame is detected until `rx` returns to 1.
- **Overrun.** With `ready` = 0, send 0x11 then 0x22 back-to-back.
  - `overrun` pulses at the second load.
  - `data_out` = 0x22 and `valid` = 1.
  - Raising `ready` clears `valid` on the next edge.
- **Simultaneous consume/load.** Assert `ready` for one cycle exactly on the second frame's load edge.
  - `valid` stays 1 and `data_out` holds the new word.
  - `overrun` = 0.
